panel_scan: RTL and testbench



---
 rtl/panel_scan.sv | 210 +++++++++++++++++++++
 tb/tb_panel_scan.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_scan.sv
// panel_scan: HUB75 scan engine for a 32x32 panel (1/16 multiplexed).
// Reads the double-buffered 12-bit frame RAM, applies 4-bit binary-coded
// modulation per colour and drives the panel shift/latch/blank pins.
//
// Ports:
//   clk            panel clock
//   rst            synchronous reset, active high
//   enable         scan enable; a drop finishes the current display period, then idles
//   buffer_select  requested display buffer, sampled only at frame boundaries
//   buffer_current buffer currently being displayed
//   rd_addr        frame RAM address {buffer, row[4:0], col[4:0]}
//   rd_data        frame RAM data (one clock after rd_addr), R[11:8] G[7:4] B[3:0]
//   frame_done     one-clock pulse on the last display clock of a frame
//   r0/g0/b0       upper-half pixel bit for the current bit plane
//   r1/g1/b1       lower-half pixel bit for the current bit plane
//   a              row address
//   blank          output disable (1 = dark)
//   latch          latch strobe
//   sclk           shift clock
module panel_scan #(
  parameter int unsigned BASE_TIME = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        buffer_select,
  output logic        buffer_current,
  output logic [10:0] rd_addr,
  input  logic [11:0] rd_data,
  output logic        frame_done,
  output logic        r0,
  output logic        g0,
  output logic        b0,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic [3:0]  a,
  output logic        blank,
  output logic        latch,
  output logic        sclk
);

  localparam int unsigned KW         = 8;    // shift-phase clock counter width
  localparam int unsigned SHIFT_LAST = 129;  // last clock of the shift phase
  localparam int unsigned COL_END    = 128;  // first k past the column fetch window
  localparam int unsigned SCLK_FIRST = 4;    // first k carrying a shift clock
  localparam int unsigned DCW        = $clog2(BASE_TIME * 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t         state, state_d;
  logic [KW-1:0]  k, k_d;
  logic [DCW-1:0] dcnt, dcnt_d;
  logic [3:0]     row, row_d;
  logic [1:0]     plane, plane_d;
  logic [11:0]    upper_q;

  logic           buf_d;
  logic [10:0]    rd_addr_d;
  logic [3:0]     a_d;
  logic           blank_d, latch_d, sclk_d, frame_done_d;
  logic           col_active;

  // Index of the last display clock for a given bit plane.
  function automatic logic [DCW-1:0] disp_last(input logic [1:0] p);
    return DCW'((BASE_TIME << p) - 1);
  endfunction

  // Next-state logic; outputs are derived from the next state so that the
  // registered pins line up with the cycle they describe.
  always_comb begin
    state_d      = state;
    k_d          = k;
    dcnt_d       = dcnt;
    row_d        = row;
    plane_d      = plane;
    buf_d        = buffer_current;
    rd_addr_d    = rd_addr;
    a_d          = a;
    blank_d      = 1'b1;
    latch_d      = 1'b0;
    sclk_d       = 1'b0;
    frame_done_d = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (enable) begin
          state_d = S_SHIFT;
          k_d     = '0;
          row_d   = '0;
          plane_d = '0;
          buf_d   = buffer_select;
        end
      end
      S_SHIFT: begin
        if (k == KW'(SHIFT_LAST)) begin
          state_d = S_LATCH;
        end else begin
          k_d = k + KW'(1);
        end
      end
      S_LATCH: begin
        state_d = S_DISPLAY;
        dcnt_d  = '0;
      end
      S_DISPLAY: begin
        if (dcnt == disp_last(plane)) begin
          k_d = '0;
          // Row counter wraps 15 -> 0 on its own at the end of a frame.
          if (plane == 2'd3) begin
            plane_d = '0;
            row_d   = row + 4'd1;
          end else begin
            plane_d = plane + 2'd1;
          end
          if (!enable) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SHIFT;
            if (plane == 2'd3 && row == 4'hF) begin
              buf_d = buffer_select;
            end
          end
        end else begin
          dcnt_d = dcnt + DCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    blank_d = (state_d != S_DISPLAY);
    latch_d = (state_d == S_LATCH);
    // Two-clock-wide shift pulse at k = 4c+4, 4c+5.
    sclk_d  = (state_d == S_SHIFT) && (k_d >= KW'(SCLK_FIRST)) && !k_d[1];
    if (latch_d) begin
      a_d = row_d;
    end
    // Upper pixel address at k = 4c, lower (row+16) at k = 4c+1.
    if (state_d == S_SHIFT && k_d < KW'(COL_END) && !k_d[1]) begin
      rd_addr_d = {buf_d, k_d[0], row_d, k_d[6:2]};
    end
    frame_done_d = (state_d == S_DISPLAY) && (dcnt_d == disp_last(plane_d)) &&
                   (plane_d == 2'd3) && (row_d == 4'hF);
  end

  // State and control-pin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      k              <= '0;
      dcnt           <= '0;
      row            <= '0;
      plane          <= '0;
      buffer_current <= 1'b0;
      rd_addr        <= '0;
      a              <= '0;
      blank          <= 1'b1;
      latch          <= 1'b0;
      sclk           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_d;
      k              <= k_d;
      dcnt           <= dcnt_d;
      row            <= row_d;
      plane          <= plane_d;
      buffer_current <= buf_d;
      rd_addr        <= rd_addr_d;
      a              <= a_d;
      blank          <= blank_d;
      latch          <= latch_d;
      sclk           <= sclk_d;
      frame_done     <= frame_done_d;
    end
  end

  assign col_active = (state == S_SHIFT) && (k < KW'(COL_END));

  // Pixel pipeline: upper pixel arrives at k = 4c+1, lower at k = 4c+2;
  // both halves update together so the pins change at k = 4c+3.
  always_ff @(posedge clk) begin
    if (rst) begin
      upper_q <= '0;
      r0      <= 1'b0;
      g0      <= 1'b0;
      b0      <= 1'b0;
      r1      <= 1'b0;
      g1      <= 1'b0;
      b1      <= 1'b0;
    end else begin
      if (col_active && k[1:0] == 2'd1) begin
        upper_q <= rd_data;
      end
      if (col_active && k[1:0] == 2'd2) begin
        r0 <= upper_q[4'd8 + 4'(plane)];
        g0 <= upper_q[4'd4 + 4'(plane)];
        b0 <= upper_q[4'(plane)];
        r1 <= rd_data[4'd8 + 4'(plane)];
        g1 <= rd_data[4'd4 + 4'(plane)];
        b1 <= rd_data[4'(plane)];
      end
    end
  end

endmodule

// File: tb/tb_panel_scan.sv
// Testbench for panel_scan: frame-position reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_panel_scan;

  localparam int BT       = 32;
  localparam int SEG0     = 131;              // shift + latch clocks per plane
  localparam int ROW_LEN  = 4 * SEG0 + BT * 15;
  localparam int FRAME    = 16 * ROW_LEN;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        buffer_select = 1'b0;
  logic        buffer_current;
  logic [10:0] rd_addr;
  logic [11:0] rd_data = '0;
  logic        frame_done, r0, g0, b0, r1, g1, b1;
  logic [3:0]  a;
  logic        blank, latch, sclk;

  logic [11:0] mem [0:2047];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state: position within the frame.
  bit         m_valid = 0;
  bit         m_run   = 0;
  int         m_t     = 0;
  logic       m_buf   = 1'b0;
  logic [3:0] m_a     = '0;
  logic [10:0] m_addr = '0;
  logic [5:0] m_px    = '0;

  // Observation state for directed checks.
  int         edge_cnt  = 0;
  int         low_cnt   = 0;
  logic       prev_sclk = 1'b0;
  logic       prev_blank = 1'b1;
  logic [5:0] snap      = '0;
  logic [5:0] pend_px   = '0;
  int         pend_row  = 0;
  logic [5:0] cap [16][4];
  int         lat_row [$];
  int         lat_dur [$];

  panel_scan #(.BASE_TIME(BT)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .buffer_select (buffer_select),
    .buffer_current(buffer_current),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .frame_done    (frame_done),
    .r0            (r0),
    .g0            (g0),
    .b0            (b0),
    .r1            (r1),
    .g1            (g1),
    .b1            (b1),
    .a             (a),
    .blank         (blank),
    .latch         (latch),
    .sclk          (sclk)
  );

  always #5 clk = ~clk;

  // Frame RAM with one clock of read latency.
  always @(posedge clk) rd_data <= mem[rd_addr];

  function automatic logic [25:0] act_vec();
    return {buffer_current, rd_addr, frame_done, r0, g0, b0, r1, g1, b1, a, blank, latch, sclk};
  endfunction

  function automatic logic [2:0] rgb_bits(input logic [11:0] pix, input int p);
    logic [11:0] v;
    v = pix >> p;
    return {v[8], v[4], v[0]};
  endfunction

  function automatic void decode(input int tt, output int row, output int pl, output int s);
    row = tt / ROW_LEN;
    s   = tt % ROW_LEN;
    pl  = 0;
    while (s >= SEG0 + (BT << pl)) begin
      s  = s - (SEG0 + (BT << pl));
      pl = pl + 1;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int row, pl, s, c;
    logic [11:0] up, lo;
    logic [25:0] exp;
    bit ex_blank, ex_latch, ex_sclk, ex_fd;
    if (rst) begin
      m_valid = 1;
      m_run   = 0;
      m_t     = 0;
      m_buf   = 1'b0;
      m_a     = '0;
      m_addr  = '0;
      m_px    = '0;
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1;
        m_t   = 0;
        m_buf = buffer_select;
      end
    end else begin
      decode(m_t, row, pl, s);
      if (s == SEG0 + (BT << pl) - 1) begin
        if (!enable) m_run = 0;
        else if (m_t == FRAME - 1) begin
          m_t   = 0;
          m_buf = buffer_select;
        end else m_t++;
      end else m_t++;
    end
    ex_blank = 1; ex_latch = 0; ex_sclk = 0; ex_fd = 0;
    if (m_run) begin
      decode(m_t, row, pl, s);
      if (s == 130) m_a = 4'(row);
      if (s < 128 && (s % 4) < 2) m_addr = {m_buf, 1'(s % 4), 4'(row), 5'(s / 4)};
      if (s < 128 && (s % 4) == 3) begin
        c    = s / 4;
        up   = mem[{m_buf, 1'b0, 4'(row), 5'(c)}];
        lo   = mem[{m_buf, 1'b1, 4'(row), 5'(c)}];
        m_px = {rgb_bits(up, pl), rgb_bits(lo, pl)};
      end
      ex_blank = !(s > 130);
      ex_latch = (s == 130);
      ex_sclk  = (s >= 4) && (s < 130) && ((s % 4) < 2);
      ex_fd    = (m_t == FRAME - 1);
    end
    exp = {m_buf, m_addr, ex_fd, m_px, m_a, ex_blank, ex_latch, ex_sclk};
    if (m_valid) chk("outputs", 32'(act_vec()), 32'(exp));
  endtask

  task automatic monitor();
    if (rst) begin
      edge_cnt = 0;
      low_cnt  = 0;
    end else begin
      if (sclk && !prev_sclk) begin
        edge_cnt++;
        if (edge_cnt == 8) snap = {r0, g0, b0, r1, g1, b1};
      end
      if (latch) begin
        pend_row = int'(a);
        pend_px  = snap;
        edge_cnt = 0;
      end
      if (!blank) low_cnt++;
      else if (!prev_blank) begin
        lat_row.push_back(pend_row);
        lat_dur.push_back(low_cnt);
        for (int p = 0; p < 4; p++) if (low_cnt == (BT << p)) cap[pend_row][p] = pend_px;
        low_cnt = 0;
      end
    end
    prev_sclk  = sclk;
    prev_blank = blank;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    monitor();
    #1;
  endtask

  task automatic wait_latch(output int n);
    n = 0;
    do begin step(); n++; end while (!latch && n < 400);
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin step(); n++; end while (!frame_done && n < 20000);
  endtask

  task automatic display_len(output int cnt);
    int guard;
    cnt = 0;
    guard = 0;
    step();
    while (!blank && guard < 400) begin cnt++; step(); guard++; end
  endtask

  localparam logic [25:0] RESET_VEC = 26'h0000004;

  initial begin
    int n, edges, quiet, t1, cnt, ok, idx;
    logic [31:0] mask;
    logic ps;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    for (int r = 0; r < 16; r++) for (int p = 0; p < 4; p++) cap[r][p] = '0;
    mem[0] = 12'hF00;
    for (int b = 0; b < 2; b++) begin
      mem[{1'(b), 5'd5, 5'd7}]  = 12'hA5C;
      mem[{1'(b), 5'd21, 5'd7}] = 12'h3C1;
    end

    // Reset values
    repeat (3) step();
    chk("reset_state", 32'(act_vec()), 32'(RESET_VEC));
    rst = 1'b0;
    enable = 1'b1;

    // First shift/latch/display of row 0 plane 0
    edges = 0; mask = '0; ps = 1'b0; n = 0;
    do begin
      step(); n++;
      if (sclk && !ps) begin
        if (edges < 32) mask[edges] = r0;
        edges++;
      end
      ps = sclk;
    end while (!latch && n < 400);
    chk("first_latch_cycle", 32'(n), 32'd131);
    chk("sclk_edges", 32'(edges), 32'd32);
    chk("r0_column_mask", mask, 32'h1);
    chk("first_latch_row", 32'(a), 32'd0);
    display_len(cnt);
    chk("plane0_display_len", 32'(cnt), 32'd32);

    // Buffer request mid-frame must wait for the frame boundary
    repeat (8000) step();
    buffer_select = 1'b1;
    wait_fd(n);
    chk("frame1_done_seen", 32'(frame_done), 32'd1);
    chk("buf_held", 32'(buffer_current), 32'd0);
    chk("addr_buf_held", 32'(rd_addr[10]), 32'd0);
    t1 = cyc;
    step();
    chk("buf_switched", 32'(buffer_current), 32'd1);
    chk("first_addr_new_buf", 32'(rd_addr), 32'h400);
    lat_row.delete();
    lat_dur.delete();

    // Full frame 2: period, latch sequence, BCM bit selection
    wait_fd(n);
    chk("frame2_done_seen", 32'(frame_done), 32'd1);
    chk("frame_period", 32'(cyc - t1), 32'd16064);
    step();
    chk("latch_count", 32'(lat_row.size()), 32'd64);
    for (int r = 0; r < 16; r++) begin
      ok = 1;
      for (int p = 0; p < 4; p++) begin
        idx = r * 4 + p;
        if (idx >= lat_row.size()) ok = 0;
        else if (lat_row[idx] != r || lat_dur[idx] != (32 << p)) ok = 0;
      end
      chk($sformatf("row%0d_latches", r), 32'(ok), 32'd1);
    end
    // {r0,g0,b0,r1,g1,b1} for A5C / 3C1 from R[11:8] G[7:4] B[3:0]
    chk("bcm_plane0", 32'(cap[5][0]), 32'b010_101);
    chk("bcm_plane1", 32'(cap[5][1]), 32'b100_100);
    chk("bcm_plane2", 32'(cap[5][2]), 32'b011_010);
    chk("bcm_plane3", 32'(cap[5][3]), 32'b101_010);

    // Enable dropped during row 3 plane 1 display (frame position 3316)
    repeat (3316) step();
    chk("in_row3_plane1_display", 32'(blank), 32'd0);
    enable = 1'b0;
    cnt = 0;
    do begin step(); cnt++; end while (!blank && cnt < 300);
    chk("display_drain_len", 32'(cnt), 32'd54);
    quiet = 0;
    repeat (200) begin
      step();
      if (!blank || sclk || latch) quiet++;
    end
    chk("idle_quiet", 32'(quiet), 32'd0);
    enable = 1'b1;
    wait_latch(n);
    chk("restart_latch_cycle", 32'(n), 32'd131);
    chk("restart_row", 32'(a), 32'd0);

    // Reset during row 0 plane 1 shift at k = 50
    repeat (83) step();
    rst = 1'b1;
    step();
    chk("reset_midshift", 32'(act_vec()), 32'(RESET_VEC));
    step();
    step();
    rst = 1'b0;
    wait_latch(n);
    chk("post_reset_latch_cycle", 32'(n), 32'd131);
    chk("post_reset_row", 32'(a), 32'd0);
    display_len(cnt);
    chk("post_reset_display_len", 32'(cnt), 32'd32);
    repeat (300) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
